// File: rtl/explosion_pkg.sv
// Shared constants, state type and address helper for the explosion sprite controller.
package explosion_pkg;

    localparam int SPRITE_W   = 32;
    localparam int SPRITE_H   = 32;
    localparam int NUM_FRAMES = 8;
    localparam int FRAME_HOLD = 4;

    localparam int FRAME_PIX = SPRITE_W * SPRITE_H;
    localparam int ADDR_W    = $clog2(FRAME_PIX * NUM_FRAMES);
    localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);

    // Dark background colour of the explosion artwork
    localparam logic [3:0] TRANSPARENT_INDEX = 4'd1;

    typedef enum logic {IDLE, PLAY} state_t;

    // ROM address of pixel (dx,dy) inside the given animation frame
    function automatic logic [ADDR_W-1:0] sprite_addr(input logic [FRAME_W-1:0] frame,
                                                      input logic [10:0] dx,
                                                      input logic [10:0] dy);
        return ADDR_W'(int'(frame) * FRAME_PIX + int'(dy) * SPRITE_W + int'(dx));
    endfunction

endpackage

// File: rtl/explosion_frame_timer.sv
// Animation timebase: detects vsync falling edges and counts hold/frame,
// flagging the tick that ends the final animation frame.
module explosion_frame_timer
    import explosion_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               vs,
    input  logic               clear,
    input  logic               run,
    output logic [FRAME_W-1:0] frame,
    output logic               last_tick
);

    logic              vs_prev;
    logic              tick;
    logic [HOLD_W-1:0] hold;

    assign tick      = vs_prev & ~vs;
    assign last_tick = run & tick & (frame == FRAME_LAST) & (hold == HOLD_LAST);

    // Previous vsync level for falling-edge detection (idle high)
    always_ff @(posedge clk) begin
        if (rst) vs_prev <= 1'b1;
        else     vs_prev <= vs;
    end

    // Hold and frame counters advance only while the animation plays
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hold  <= '0;
            frame <= '0;
        end else if (run && tick) begin
            if (hold == HOLD_LAST) begin
                hold  <= '0;
                frame <= frame + 1'b1;
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end

endmodule

// File: rtl/explosion_sprite_ctrl.sv
// Explosion sprite controller: plays the 8-frame explosion at a latched
// position and streams ROM colour indices to the palette, 3-cycle latency.
// Optional build macro EXPLOSION_TRANSPARENT_EN: ROM index TRANSPARENT_INDEX
// is treated as see-through (pix_on=0, pix_index=0).
module explosion_sprite_ctrl
    import explosion_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vs,
    input  logic              trigger,
    input  logic [9:0]        trig_x,
    input  logic [9:0]        trig_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_index,
    output logic              pix_on,
    output logic              busy,
    output logic              done
);

    state_t             state_q, state_d;
    logic               start;
    logic [9:0]         pos_x, pos_y;
    logic [FRAME_W-1:0] frame;
    logic               last_tick;
    logic               in_box_p0;
    logic [10:0]        dx_p0, dy_p0;
    logic               vld_p1, vld_p2;
    logic               opaque_p2;

    explosion_frame_timer u_timer (
        .clk       (Clk),
        .rst       (Reset),
        .vs        (vs),
        .clear     (start),
        .run       (state_q == PLAY),
        .frame     (frame),
        .last_tick (last_tick)
    );

    assign busy = (state_q == PLAY);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: triggers only honoured from IDLE; final tick returns to IDLE
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (trigger) begin
                start   = 1'b1;
                state_d = PLAY;
            end
            PLAY: if (last_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sprite position captured with the accepted trigger
    always_ff @(posedge Clk) begin
        if (start) begin
            pos_x <= trig_x;
            pos_y <= trig_y;
        end
    end

    // Completion pulse, one cycle after the final tick
    always_ff @(posedge Clk) begin
        if (Reset) done <= 1'b0;
        else       done <= last_tick;
    end

    // ---- stage p0: box test in 11 bits so x+SPRITE_W cannot wrap ----
    assign dx_p0 = {1'b0, DrawX} - {1'b0, pos_x};
    assign dy_p0 = {1'b0, DrawY} - {1'b0, pos_y};
    assign in_box_p0 = (state_q == PLAY)
                     && ({1'b0, DrawX} >= {1'b0, pos_x})
                     && ({1'b0, DrawX} <  {1'b0, pos_x} + 11'(SPRITE_W))
                     && ({1'b0, DrawY} >= {1'b0, pos_y})
                     && ({1'b0, DrawY} <  {1'b0, pos_y} + 11'(SPRITE_H));

    // ---- stage p1: ROM address register, in-box flag travels alongside ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            vld_p1   <= 1'b0;
        end else begin
            rom_addr <= in_box_p0 ? sprite_addr(frame, dx_p0, dy_p0) : '0;
            vld_p1   <= in_box_p0;
        end
    end

    // ---- stage p2: wait for the synchronous ROM read ----
    always_ff @(posedge Clk) begin
        if (Reset) vld_p2 <= 1'b0;
        else       vld_p2 <= vld_p1;
    end

`ifdef EXPLOSION_TRANSPARENT_EN
    assign opaque_p2 = (rom_data != TRANSPARENT_INDEX);
`else
    assign opaque_p2 = 1'b1;
`endif

    // ---- stage p3: palette outputs, zero when off-sprite ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_on    <= 1'b0;
            pix_index <= 4'd0;
        end else begin
            pix_on    <= vld_p2 & opaque_p2;
            pix_index <= (vld_p2 && opaque_p2) ? rom_data : 4'd0;
        end
    end

endmodule

// File: tb/tb_explosion_sprite_ctrl.sv
// Scoreboard bench for explosion_sprite_ctrl: a behavioural model predicts
// every cycle's outputs, a separate monitor compares them at the DUT latency.
module tb_explosion_sprite_ctrl;

    localparam int SW = 32;
    localparam int SH = 32;
    localparam int NF = 8;
    localparam int FH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        vs = 1'b1;
    logic        trigger = 1'b0;
    logic [9:0]  trig_x = '0, trig_y = '0, DrawX = '0, DrawY = '0;
    logic [12:0] rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic [3:0]  pix_index;
    logic        pix_on, busy, done;

    explosion_sprite_ctrl dut (
        .Clk(Clk), .Reset(Reset), .vs(vs), .trigger(trigger),
        .trig_x(trig_x), .trig_y(trig_y), .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_index(pix_index),
        .pix_on(pix_on), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    logic [3:0] rom_mem [0:8191];

    // Synchronous ROM model
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic       b;
        logic       d;
        logic [12:0] a;
        logic       on;
        logic [3:0] ix;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q3[$];

    int checks = 0;
    int errors = 0;

    // Model state: what the block holds during the current cycle
    bit m_play = 0;
    int m_x = 0, m_y = 0;
    int m_ticks = 0;
    bit m_vsprev = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations when the matching output is due
    exp_t me;
    always @(negedge Clk) begin
        if (q0.size() > 0 && q0[0].tag == cyc) begin
            me = q0.pop_front();
            chk("busy", busy, me.b);
        end
        if (q1.size() > 0 && q1[0].tag + 1 == cyc) begin
            me = q1.pop_front();
            chk("done", done, me.d);
            chk("rom_addr", rom_addr, me.a);
        end
        if (q3.size() > 0 && q3[0].tag + 3 == cyc) begin
            me = q3.pop_front();
            chk("pix_on", pix_on, me.on);
            chk("pix_index", pix_index, me.ix);
        end
    end

    // One clock of stimulus plus the model's prediction for it
    task automatic step(input bit rst, input bit trig, input int tx, input int ty,
                        input bit vsv, input int dx, input int dy);
        exp_t e, t;
        bit tick;
        int fr;
        @(posedge Clk); #1;
        Reset = rst; trigger = trig; trig_x = 10'(tx); trig_y = 10'(ty);
        vs = vsv; DrawX = 10'(dx); DrawY = 10'(dy);
        e.tag = cyc; e.b = m_play; e.d = 0; e.a = '0; e.on = 0; e.ix = '0;
        if (rst) begin
            foreach (q3[i]) if (q3[i].tag >= cyc - 2) begin
                t = q3[i]; t.on = 0; t.ix = '0; q3[i] = t;
            end
            m_play = 0; m_ticks = 0; m_vsprev = 1;
        end else begin
            if (m_play && dx >= m_x && dx < m_x + SW && dy >= m_y && dy < m_y + SH) begin
                fr = m_ticks / FH;
                e.a = 13'(fr * SW * SH + (dy - m_y) * SW + (dx - m_x));
                e.ix = rom_mem[e.a];
                e.on = 1;
`ifdef EXPLOSION_TRANSPARENT_EN
                if (e.ix == 4'd1) begin e.on = 0; e.ix = '0; end
`endif
            end
            tick = m_vsprev && !vsv;
            m_vsprev = vsv;
            if (m_play) begin
                if (tick) begin
                    m_ticks++;
                    if (m_ticks == NF * FH) begin
                        e.d = 1; m_play = 0; m_ticks = 0;
                    end
                end
            end else if (trig) begin
                m_play = 1; m_x = tx; m_y = ty; m_ticks = 0;
            end
        end
        q0.push_back(e); q1.push_back(e); q3.push_back(e);
    endtask

    function automatic int near(input int base);
        int v;
        v = base - 4 + int'($urandom_range(0, 40));
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    task automatic near_steps(input int n, input bit vsv);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, vsv, near(m_x), near(m_y));
    endtask

    // One vsync falling edge followed by n idle-high cycles near the sprite
    task automatic vs_edge(input int n);
        step(0, 0, 0, 0, 0, near(m_x), near(m_y));
        near_steps(n, 1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        rom_mem[0] = 4'd1;
        rom_mem[1] = 4'd2;

        repeat (3) @(posedge Clk);
        #1;
        chk("reset rom_addr", rom_addr, 0);
        chk("reset pix_on", pix_on, 0);
        chk("reset pix_index", pix_index, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);

        // Idle sweep: nothing may draw
        for (int i = 0; i < 40; i++)
            step(0, 0, 0, 0, 1, $urandom_range(0, 639), $urandom_range(0, 479));

        // Trigger at (100,50) and probe corners/edges
        step(0, 1, 100, 50, 1, 0, 0);
        step(0, 0, 0, 0, 1, 100, 50);
        step(0, 0, 0, 0, 1, 101, 50);
        step(0, 0, 0, 0, 1, 131, 81);
        step(0, 0, 0, 0, 1, 132, 81);
        step(0, 0, 0, 0, 1, 99, 50);
        step(0, 0, 0, 0, 1, 100, 49);
        step(0, 0, 0, 0, 1, 131, 82);
        near_steps(40, 1);

        // Full animation: second trigger at frame 3, trigger on completion tick
        for (int ed = 1; ed <= NF * FH; ed++) begin
            step(0, ed == NF * FH, 200, 100, 0, near(m_x), near(m_y));
            if (ed == FH) step(0, 0, 0, 0, 1, 100, 50);
            if (ed == 3 * FH) step(0, 1, 300, 300, 1, 300, 300);
            near_steps(2, 1);
        end
        step(0, 0, 0, 0, 1, 100, 50);
        step(0, 0, 0, 0, 1, 200, 100);
        near_steps(4, 1);

        // Right screen edge
        step(0, 1, 620, 200, 1, 0, 0);
        step(0, 0, 0, 0, 1, 639, 200);
        step(0, 0, 0, 0, 1, 0, 200);
        step(0, 0, 0, 0, 1, 620, 231);
        step(0, 0, 0, 0, 1, 651, 231);
        step(0, 0, 0, 0, 1, 652, 231);
        near_steps(10, 1);

        // Reset at frame 5, then confirm nothing resumes
        step(0, 0, 0, 0, 1, 0, 0);
        for (int ed = 0; ed < 5 * FH; ed++) vs_edge(2);
        step(1, 0, 0, 0, 1, near(m_x), near(m_y));
        for (int ed = 0; ed < 3 * FH; ed++) vs_edge(2);

        // Randomized mixture
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) != 0)
                step($urandom_range(0, 399) == 0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 639), $urandom_range(0, 479),
                     $urandom_range(0, 5) != 0, near(m_x), near(m_y));
            else
                step(0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 639), $urandom_range(0, 479),
                     $urandom_range(0, 5) != 0,
                     $urandom_range(0, 639), $urandom_range(0, 479));
        end

        repeat (5) @(posedge Clk);
        #1;
        chk("drain q0", q0.size(), 0);
        chk("drain q1", q1.size(), 0);
        chk("drain q3", q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
